// File: rtl/vga_pkg.sv
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] VGA_FB_BASE    = 32'h3E80;
  localparam int          WORDS_PER_LINE = 4;
  localparam int          DISPLAY_LINES  = 96;
  localparam int          DISPLAY_WIDTH  = 128;

  function automatic logic [31:0] line_addr(input logic [31:0] base,
                                            input logic [6:0]  line,
                                            input logic [1:0]  idx);
    return base + {23'd0, line, 2'b00} + {30'd0, idx};
  endfunction

endpackage

// File: rtl/vga_line_bank.sv
// Two line banks of four 32-bit words: one write port, one combinational read port.
module vga_line_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        wr_bank,
    input  logic [1:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic        rd_bank,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_data
);

    logic [31:0] mem [2][4];

    // Storage: cleared on reset so the display reads black until a line lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 4; w++) begin
                    mem[b][w] <= '0;
                end
            end
        end else if (we) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/vga_line_prefetch.sv
// Double-buffered line prefetcher: fills the back bank from SRAM during
// blanking and swaps it to the front at each line boundary.
module vga_line_prefetch #(
    parameter logic [31:0] BASE_ADDR      = 32'h3E80,
    parameter int          WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [6:0]  line_index,
    input  logic        line_swap,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  rd_word_idx,
    output logic [31:0] rd_data,
    output logic        fetch_busy,
    output logic        back_valid,
    output logic        underrun,
    output logic        overrun
);

    import vga_pkg::*;

    localparam logic [1:0] LAST_IDX = 2'(WORDS_PER_LINE - 1);

    fetch_state_t state;
    logic [6:0]   line_q;
    logic [1:0]   word_cnt;
    logic         front_sel;
    logic         bank_we;

    // Only acks that answer our own outstanding request write the back bank.
    assign bank_we    = (state == REQ) && mem_ack;
    assign fetch_busy = (state != IDLE);
    assign mem_sel    = {4{mem_req}};

    vga_line_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .wr_bank (~front_sel),
        .wr_idx  (word_cnt),
        .wr_data (mem_rdata),
        .rd_bank (front_sel),
        .rd_idx  (rd_word_idx),
        .rd_data (rd_data)
    );

    // Fetch FSM, bank swap and sticky error flags. Swap is evaluated first so
    // that a same-cycle final ack (which sets back_valid) wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            line_q     <= '0;
            word_cnt   <= '0;
            front_sel  <= 1'b0;
            back_valid <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            if (line_swap) begin
                if (back_valid) begin
                    front_sel  <= ~front_sel;
                    back_valid <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end

            if (fetch_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fetch_start) begin
                        line_q     <= line_index;
                        word_cnt   <= '0;
                        back_valid <= 1'b0;
                        mem_req    <= 1'b1;
                        mem_addr   <= line_addr(BASE_ADDR, line_index, 2'd0);
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (word_cnt == LAST_IDX) begin
                            back_valid <= 1'b1;
                            mem_req    <= 1'b0;
                            mem_addr   <= '0;
                            state      <= DONE;
                        end else begin
                            word_cnt <= 2'(word_cnt + 2'd1);
                            mem_addr <= line_addr(BASE_ADDR, line_q, 2'(word_cnt + 2'd1));
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_req  <= 1'b0;
                    mem_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed/randomized bench for vga_line_prefetch with an SRAM responder and
// a line-level reference model (front line, back line, flags).
module tb_vga_line_prefetch;

    import vga_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_start;
    logic [6:0]  line_index;
    logic        line_swap;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [1:0]  rd_word_idx;
    logic [31:0] rd_data;
    logic        fetch_busy;
    logic        back_valid;
    logic        underrun;
    logic        overrun;

    vga_line_prefetch #(
        .BASE_ADDR      (32'h3E80),
        .WORDS_PER_LINE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .line_index  (line_index),
        .line_swap   (line_swap),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_sel     (mem_sel),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .rd_word_idx (rd_word_idx),
        .rd_data     (rd_data),
        .fetch_busy  (fetch_busy),
        .back_valid  (back_valid),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] seed;

    // Reference model: contents of the displayed line and the pending line.
    logic [31:0] exp_front [4];
    logic [31:0] exp_back  [4];
    logic        exp_bv;
    logic        exp_under;
    logic        exp_over;

    // SRAM responder state.
    int          wait_cycles = 0;
    int          cnt = 0;
    int          unstable = 0;
    logic [31:0] held_addr = '0;
    logic [31:0] addr_log [$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    function automatic logic [31:0] addr_of(input int line, input int k);
        return 32'h3E80 + 32'(line * 4 + k);
    endfunction

    // SRAM model: acks each request after wait_cycles idle cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req && !rst) begin
                if (cnt > 0 && mem_addr !== held_addr) unstable++;
                held_addr = mem_addr;
                cnt++;
                if (cnt > wait_cycles) begin
                    mem_ack   = 1'b1;
                    mem_rdata = data_of(mem_addr);
                    addr_log.push_back(mem_addr);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic read_front(input string tag);
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            rd_word_idx = 2'(k);
            #1;
            check($sformatf("%s_rd%0d", tag, k), rd_data, exp_front[k]);
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_bv"},    {31'd0, back_valid}, {31'd0, exp_bv});
        check({tag, "_under"}, {31'd0, underrun},   {31'd0, exp_under});
        check({tag, "_over"},  {31'd0, overrun},    {31'd0, exp_over});
    endtask

    // Drives line_swap for one cycle and applies the swap rule to the model.
    task automatic pulse_swap();
        line_swap = 1'b1;
        if (exp_bv) begin
            exp_front = exp_back;
            exp_bv    = 1'b0;
        end else begin
            exp_under = 1'b1;
        end
        @(negedge clk);
        line_swap = 1'b0;
    endtask

    // Raises fetch_start (caller clears it at the next negedge).
    task automatic start_fetch(input int line, input int w);
        wait_cycles = w;
        unstable    = 0;
        addr_log.delete();
        line_index  = 7'(line);
        fetch_start = 1'b1;
        for (int k = 0; k < 4; k++) exp_back[k] = data_of(addr_of(line, k));
        exp_bv = 1'b0;
    endtask

    // Waits for the line to land; edges = posedges already elapsed since start.
    task automatic complete_fetch(input int line, input int w, input int edges0, input string tag);
        int edges;
        edges = edges0;
        while (!back_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(4 * (w + 1)));
        exp_bv = 1'b1;
        check({tag, "_nwords"}, 32'(addr_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check($sformatf("%s_addr%0d", tag, k), addr_log[k], addr_of(line, k));
        check({tag, "_addr_stable"}, 32'(unstable), 32'd0);
        check({tag, "_busy_done"}, {31'd0, fetch_busy}, 32'd1);
        @(negedge clk);
        check({tag, "_busy_idle"}, {31'd0, fetch_busy}, 32'd0);
        check({tag, "_req_idle"},  {31'd0, mem_req},    32'd0);
        check({tag, "_addr_idle"}, mem_addr,            32'd0);
        check_flags(tag);
    endtask

    task automatic run_fetch(input int line, input int w, input string tag);
        start_fetch(line, w);
        @(negedge clk);
        fetch_start = 1'b0;
        check({tag, "_req"},  {31'd0, mem_req},    32'd1);
        check({tag, "_sel"},  {28'd0, mem_sel},    32'hF);
        check({tag, "_a0"},   mem_addr,            addr_of(line, 0));
        check({tag, "_busy"}, {31'd0, fetch_busy}, 32'd1);
        complete_fetch(line, w, 0, tag);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            exp_front[k] = '0;
            exp_back[k]  = '0;
        end
        exp_bv    = 1'b0;
        exp_under = 1'b0;
        exp_over  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int la, lb, lr;
        seed        = $urandom;
        rst         = 1'b1;
        fetch_start = 1'b0;
        line_index  = '0;
        line_swap   = 1'b0;
        rd_word_idx = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            rd_word_idx = 2'(i % 4);
            #1;
            check("idle_rd",   rd_data,             32'd0);
            check("idle_req",  {31'd0, mem_req},    32'd0);
            check("idle_sel",  {28'd0, mem_sel},    32'd0);
            check("idle_addr", mem_addr,            32'd0);
            check("idle_busy", {31'd0, fetch_busy}, 32'd0);
            check_flags("idle");
            @(negedge clk);
        end

        // Line 5, zero-wait SRAM, then swap to front.
        run_fetch(5, 0, "line5");
        pulse_swap();
        read_front("line5_swap");
        check_flags("line5_swap");

        // Busy SRAM: three wait cycles per word.
        lr = int'($urandom_range(0, DISPLAY_LINES - 1));
        run_fetch(lr, 3, "wait3");
        pulse_swap();
        read_front("wait3_swap");

        // Underrun: swap with no pending line keeps the old line.
        pulse_swap();
        check_flags("under");
        read_front("under_rd");
        repeat (5) @(negedge clk);
        check("under_sticky", {31'd0, underrun}, 32'd1);

        // Overrun: a second start mid-fetch is ignored.
        la = int'($urandom_range(0, DISPLAY_LINES - 1));
        lb = (la + 17) % DISPLAY_LINES;
        start_fetch(la, 1);
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        line_index  = 7'(lb);
        fetch_start = 1'b1;
        exp_over    = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        complete_fetch(la, 1, 2, "ovr");

        // Swap and fetch on the same edge: swap lands, fetch fills old front.
        lb = int'($urandom_range(0, DISPLAY_LINES - 1));
        line_swap = 1'b1;
        exp_front = exp_back;
        exp_bv    = 1'b0;
        start_fetch(lb, 0);
        @(negedge clk);
        line_swap   = 1'b0;
        fetch_start = 1'b0;
        read_front("swapfetch_rd");
        complete_fetch(lb, 0, 0, "swapfetch");
        pulse_swap();
        read_front("swapfetch_new");

        // Reset after two acks.
        start_fetch(7, 0);
        @(negedge clk);
        fetch_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("rstmid_req",  {31'd0, mem_req},    32'd0);
        check("rstmid_busy", {31'd0, fetch_busy}, 32'd0);
        check("rstmid_addr", mem_addr,            32'd0);
        check_flags("rstmid");
        read_front("rstmid_rd");

        // Last display line, then one fully random fetch.
        run_fetch(DISPLAY_LINES - 1, 2, "line95");
        pulse_swap();
        read_front("line95_swap");
        lr = int'($urandom_range(0, DISPLAY_LINES - 1));
        run_fetch(lr, int'($urandom_range(0, 4)), "rand");
        pulse_swap();
        read_front("rand_swap");
        check_flags("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
